// File: rtl/idma_desc64_req_queue.sv
// idma_desc64_req_queue
//
// Decoupling and flow-control stage between the 64-bit descriptor frontend
// and the iDMA backend. Transfer requests from the frontend are buffered in
// a FIFO and dispatched to the backend only while fewer than MaxOutstanding
// transfers are awaiting a response. Backend responses return to the
// frontend through a one-entry register. A sticky error flag and an
// aggregate busy flag are derived from the traffic.
//
// Optional feature (compile-time macro IDMA_DESC64_REQ_QUEUE_HALT_ON_ERROR_EN):
//   when defined, a response carrying an error halts dispatch until clear_i.
//   When undefined, the block always stays in RUN and errors only set error_o.
//
// Ports:
//   clk_i, rst_i                        clock, synchronous active-high reset
//   req_i, req_valid_i, req_ready_o     request from frontend
//   req_o, req_valid_o, req_ready_i     request to backend
//   rsp_i, rsp_valid_i, rsp_ready_o     response from backend
//   rsp_o, rsp_valid_o, rsp_ready_i     response to frontend
//   clear_i                             single-cycle pulse, clears error/halt
//   busy_o                              work pending in the block or backend
//   fill_o                              request FIFO occupancy
//   outstanding_o                       dispatched-but-unanswered transfers
//   error_o                             sticky error flag

// Default request/response types; integrators override with their own
// structs, which must contain a `length` (request) and `error` (response).
typedef struct packed {
  logic [31:0] length;
  logic [31:0] src_addr;
} idma_desc64_req_queue_req_t;

typedef struct packed {
  logic [1:0] cause;
  logic       error;
} idma_desc64_req_queue_rsp_t;

module idma_desc64_req_queue #(
  parameter type idma_req_t     = idma_desc64_req_queue_req_t,
  parameter type idma_rsp_t     = idma_desc64_req_queue_rsp_t,
  parameter int  Depth          = 4,
  parameter int  MaxOutstanding = 8,
  localparam int FillW          = $clog2(Depth + 1),
  localparam int OutW           = $clog2(MaxOutstanding + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  idma_req_t        req_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  output idma_req_t        req_o,
  output logic             req_valid_o,
  input  logic             req_ready_i,
  input  idma_rsp_t        rsp_i,
  input  logic             rsp_valid_i,
  output logic             rsp_ready_o,
  output idma_rsp_t        rsp_o,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  input  logic             clear_i,
  output logic             busy_o,
  output logic [FillW-1:0] fill_o,
  output logic [OutW-1:0]  outstanding_o,
  output logic             error_o
);

  localparam int PtrW = $clog2(Depth);
  localparam logic [PtrW-1:0]  PtrLast = PtrW'(Depth - 1);
  localparam logic [FillW-1:0] FillMax = FillW'(Depth);
  localparam logic [OutW-1:0]  OutMax  = OutW'(MaxOutstanding);

  localparam logic [0:0] StRun  = 1'b0;
  localparam logic [0:0] StHalt = 1'b1;

  idma_req_t        mem [Depth];
  logic [PtrW-1:0]  wr_ptr, rd_ptr;
  logic [FillW-1:0] fill;
  logic [OutW-1:0]  outstanding;
  logic [0:0]       state, state_d;
  logic             error_q;
  idma_rsp_t        rsp_p1;
  logic             vld_p1;

  logic full, empty, push, pop, rsp_hs, underflow;

  assign full  = (fill == FillMax);
  assign empty = (fill == '0);

  // Ready depends on FIFO state only, so a full FIFO never accepts even if
  // the backend pops in the same cycle.
  assign req_ready_o = !full;
  assign push        = req_valid_i && !full;

  assign req_o       = mem[rd_ptr];
  assign req_valid_o = !empty && (outstanding < OutMax) && (state == StRun);
  assign pop         = req_valid_o && req_ready_i;

  // The response register drains and refills in the same cycle.
  assign rsp_ready_o = !vld_p1 || rsp_ready_i;
  assign rsp_hs      = rsp_valid_i && rsp_ready_o;
  assign underflow   = rsp_hs && (outstanding == '0);

  assign rsp_o         = rsp_p1;
  assign rsp_valid_o   = vld_p1;
  assign fill_o        = fill;
  assign outstanding_o = outstanding;
  assign error_o       = error_q;
  assign busy_o        = !empty || (outstanding != '0) || vld_p1;

`ifdef IDMA_DESC64_REQ_QUEUE_HALT_ON_ERROR_EN
  // An error response wins over a simultaneous clear, so HALT is retained.
  always_comb begin
    state_d = state;
    if (rsp_hs && rsp_i.error) begin
      state_d = StHalt;
    end else if (clear_i) begin
      state_d = StRun;
    end
  end
`else
  always_comb begin
    state_d = StRun;
  end
`endif

  // Request FIFO storage: data only, no reset.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= req_i;
    end
  end

  // Request FIFO control and dispatch accounting.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fill        <= '0;
      outstanding <= '0;
      state       <= StRun;
      error_q     <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PtrLast) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PtrLast) ? '0 : rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
      // A response with nothing in flight is forwarded but leaves the
      // counter at zero; the dispatch cap prevents overflow.
      if (pop && !rsp_hs) begin
        outstanding <= outstanding + 1'b1;
      end else if (!pop && rsp_hs && (outstanding != '0)) begin
        outstanding <= outstanding - 1'b1;
      end
      state <= state_d;
      if (rsp_hs && (rsp_i.error || underflow)) begin
        error_q <= 1'b1;
      end else if (clear_i) begin
        error_q <= 1'b0;
      end
    end
  end

  // Response stage boundary: backend response -> frontend register.
  always_ff @(posedge clk_i) begin
    if (rsp_hs) begin
      rsp_p1 <= rsp_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p1 <= 1'b0;
    end else if (rsp_hs) begin
      vld_p1 <= 1'b1;
    end else if (rsp_ready_i) begin
      vld_p1 <= 1'b0;
    end
  end

endmodule

// File: tb/tb_idma_desc64_req_queue.sv
module tb_idma_desc64_req_queue;

  localparam int Depth  = 4;
  localparam int MaxOut = 4;
  localparam int FillW  = $clog2(Depth + 1);
  localparam int OutW   = $clog2(MaxOut + 1);
`ifdef IDMA_DESC64_REQ_QUEUE_HALT_ON_ERROR_EN
  localparam int Halt = 1;
`else
  localparam int Halt = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                       rst_i;
  idma_desc64_req_queue_req_t req_i, req_o;
  logic                       req_valid_i, req_ready_o, req_valid_o, req_ready_i;
  idma_desc64_req_queue_rsp_t rsp_i, rsp_o;
  logic                       rsp_valid_i, rsp_ready_o, rsp_valid_o, rsp_ready_i;
  logic                       clear_i, busy_o, error_o;
  logic [FillW-1:0]           fill_o;
  logic [OutW-1:0]            outstanding_o;

  idma_desc64_req_queue #(
    .Depth         (Depth),
    .MaxOutstanding(MaxOut)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .req_i        (req_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_o        (req_o),
    .req_valid_o  (req_valid_o),
    .req_ready_i  (req_ready_i),
    .rsp_i        (rsp_i),
    .rsp_valid_i  (rsp_valid_i),
    .rsp_ready_o  (rsp_ready_o),
    .rsp_o        (rsp_o),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .clear_i      (clear_i),
    .busy_o       (busy_o),
    .fill_o       (fill_o),
    .outstanding_o(outstanding_o),
    .error_o      (error_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  int exp_len[$];
  int exp_rsp[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: scoreboard comparison on every handshake, sampled at negedge.
  always @(negedge clk) begin
    if (!rst_i) begin
      if (req_valid_o && req_ready_i) begin
        if (exp_len.size() == 0) chk("req_unexpected", int'(req_o.length), -1);
        else chk("req_order", int'(req_o.length), exp_len.pop_front());
      end
      if (rsp_valid_o && rsp_ready_i) begin
        if (exp_rsp.size() == 0) chk("rsp_unexpected", int'({rsp_o.cause, rsp_o.error}), -1);
        else chk("rsp_order", int'({rsp_o.cause, rsp_o.error}), exp_rsp.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int len);
    req_valid_i     = 1'b1;
    req_i.length    = len[31:0];
    req_i.src_addr  = '0;
    exp_len.push_back(len);
    tick();
    req_valid_i = 1'b0;
  endtask

  task automatic respond(input int cause, input int err);
    logic [1:0] c;
    logic       e;
    c = cause[1:0];
    e = err[0];
    rsp_valid_i = 1'b1;
    rsp_i.cause = c;
    rsp_i.error = e;
    exp_rsp.push_back(int'({c, e}));
    tick();
    rsp_valid_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1;
    req_i = '0;
    req_valid_i = 1'b0;
    req_ready_i = 1'b0;
    rsp_i = '0;
    rsp_valid_i = 1'b0;
    rsp_ready_i = 1'b1;
    clear_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b0;

    // Reset defaults
    chk("rst_fill", int'(fill_o), 0);
    chk("rst_outstanding", int'(outstanding_o), 0);
    chk("rst_req_valid", int'(req_valid_o), 0);
    chk("rst_rsp_valid", int'(rsp_valid_o), 0);
    chk("rst_error", int'(error_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_req_ready", int'(req_ready_o), 1);

    // Fill with backend stalled
    push(32'h11);
    push(32'h22);
    push(32'h33);
    push(32'h44);
    chk("full_fill", int'(fill_o), 4);
    chk("full_req_ready", int'(req_ready_o), 0);
    chk("full_req_valid", int'(req_valid_o), 1);
    chk("full_busy", int'(busy_o), 1);
    req_valid_i  = 1'b1;
    req_i.length = 32'h99;
    tick();
    req_valid_i = 1'b0;
    chk("full_no_push", int'(fill_o), 4);
    chk("stall_stable", int'(req_o.length), 32'h11);

    // Drain: four pops on consecutive cycles
    req_ready_i = 1'b1;
    repeat (4) tick();
    chk("drain_fill", int'(fill_o), 0);
    chk("drain_outstanding", int'(outstanding_o), 4);
    chk("drain_req_valid", int'(req_valid_o), 0);

    // Outstanding cap
    push(32'h55);
    chk("cap_fill", int'(fill_o), 1);
    chk("cap_blocked", int'(req_valid_o), 0);
    tick();
    chk("cap_still_blocked", int'(req_valid_o), 0);
    respond(1, 0);
    chk("cap_freed", int'(outstanding_o), 3);
    chk("cap_dispatch", int'(req_valid_o), 1);
    tick();
    chk("cap_refilled", int'(outstanding_o), 4);
    chk("cap_fill_empty", int'(fill_o), 0);

    // Response back-pressure and pass-through
    rsp_ready_i = 1'b0;
    respond(2, 0);
    chk("bp_rsp_valid", int'(rsp_valid_o), 1);
    chk("bp_rsp_ready", int'(rsp_ready_o), 0);
    tick();
    chk("bp_held", int'(rsp_o.cause), 2);
    rsp_ready_i = 1'b1;
    respond(3, 0);
    chk("pt_no_bubble", int'(rsp_valid_o), 1);
    chk("pt_data", int'(rsp_o.cause), 3);
    chk("pt_outstanding", int'(outstanding_o), 2);
    tick();
    chk("pt_drained", int'(rsp_valid_o), 0);

    // Error response
    respond(0, 1);
    chk("err_set", int'(error_o), 1);
    chk("err_outstanding", int'(outstanding_o), 1);
    push(32'h66);
    chk("err_gate", int'(req_valid_o), Halt ? 0 : 1);
    tick();
    chk("err_fill", int'(fill_o), Halt ? 1 : 0);
    chk("err_sticky", int'(error_o), 1);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    chk("err_cleared", int'(error_o), 0);
    tick();
    chk("resume_fill", int'(fill_o), 0);
    chk("resume_outstanding", int'(outstanding_o), 2);

    // Retire the remaining transfers, then underflow
    respond(0, 0);
    respond(1, 0);
    tick();
    chk("retired", int'(outstanding_o), 0);
    respond(2, 0);
    chk("uf_error", int'(error_o), 1);
    chk("uf_count", int'(outstanding_o), 0);
    tick();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    chk("uf_cleared", int'(error_o), 0);

    // Busy tracking for a single transfer
    chk("idle_busy", int'(busy_o), 0);
    push(32'h77);
    chk("busy_after_push", int'(busy_o), 1);
    chk("no_fallthrough", int'(fill_o), 1);
    tick();
    chk("busy_in_flight", int'(busy_o), 1);
    chk("busy_outstanding", int'(outstanding_o), 1);
    respond(3, 0);
    chk("busy_rsp_held", int'(busy_o), 1);
    tick();
    chk("busy_done", int'(busy_o), 0);

    // Reset mid-operation discards queued state
    req_ready_i = 1'b0;
    push(32'h88);
    push(32'h89);
    chk("mid_fill", int'(fill_o), 2);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    exp_len.delete();
    chk("mid_rst_fill", int'(fill_o), 0);
    chk("mid_rst_busy", int'(busy_o), 0);
    chk("mid_rst_req_valid", int'(req_valid_o), 0);

    tick();
    chk("req_scoreboard_empty", exp_len.size(), 0);
    chk("rsp_scoreboard_empty", exp_rsp.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
